uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter core between `N_REQ` byte-producing requesters. It grants in round-robin order, latches the winner's byte and launches the transmitter with a one-cycle `tx_start` pulse. It then tracks the transmitter's `tx_done` level (high during the stop bit) to detect frame completion. It sits between the system request sources and the UART TX top, and owns the transmitter's `start` and data inputs exclusively.

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM encoding and parameter defaults.
package uart_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] WAIT_HI = 3'd2;
  localparam logic [2:0] WAIT_LO = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam int DATA_W_DEFAULT      = 8;
  localparam int TIMEOUT_CYC_DEFAULT = 1048576;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap-around.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  // cand[k] is the requester examined k-th, i.e. (ptr + k) mod N_REQ
  logic [IDX_W-1:0] cand [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand[gi] = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                                   : sum[IDX_W-1:0];
    end
  endgenerate

  // Scan from the far end so the lowest scan position wins
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        grant = cand[k];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers;
// launches each frame and follows tx_done high then low to detect completion.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      done_pulse,
  output logic [$clog2(N_REQ)-1:0]  done_id,
  output logic                      timeout_err,
  output logic                      busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [2:0]       state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_hit;
  logic             cnt_at_limit;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [N_REQ-1:0] ack_vec;
  logic [IDX_W:0]   id_inc;
  logic [IDX_W-1:0] ptr_wrap;
  logic [DATA_W-1:0] req_bytes [N_REQ];

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (pick_idx),
    .any   (pick_any)
  );

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
      assign ack_vec[gi]   = (done_id == IDX_W'(gi));
    end
  endgenerate

  assign id_inc       = {1'b0, done_id} + 1'b1;
  assign ptr_wrap     = (id_inc == (IDX_W+1)'(N_REQ)) ? '0 : id_inc[IDX_W-1:0];
  assign cnt_at_limit = (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  // A real tx_done edge takes precedence over an expiry in the same cycle
  always_comb begin
    state_next  = state_reg;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE:    if (pick_any) state_next = START;
      START:   state_next = WAIT_HI;
      WAIT_HI: begin
        if (tx_done) begin
          state_next = WAIT_LO;
        end else if (cnt_at_limit) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_done) begin
          state_next = DONE;
        end else if (cnt_at_limit) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      req_ack     <= '0;
      done_pulse  <= 1'b0;
      done_id     <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_reg   <= state_next;
      busy        <= (state_next != IDLE);
      tx_start    <= (state_reg == START);
      req_ack     <= (state_reg == START) ? ack_vec : '0;
      done_pulse  <= (state_reg == DONE);
      timeout_err <= timeout_hit;

      if (state_reg == IDLE && pick_any) begin
        done_id <= pick_idx;
        tx_data <= req_bytes[pick_idx];
      end

      if (state_reg == START) ptr_reg <= ptr_wrap;

      // Counter restarts on every state change, so each tx_done phase gets its own budget
      if (state_next != state_reg) begin
        cnt_reg <= '0;
      end else if (state_reg == WAIT_HI || state_reg == WAIT_LO) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected grants, a monitor
// pops and compares on tx_start / done_pulse / timeout_err.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ack;
  logic           tx_start;
  logic [W-1:0]   tx_data;
  logic           tx_done = 1'b0;
  logic           done_pulse;
  logic [1:0]     done_id;
  logic           timeout_err;
  logic           busy;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .done_pulse(done_pulse), .done_id(done_id), .timeout_err(timeout_err), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int id; int data; bit abort; } exp_t;
  exp_t exp_q[$];
  int   done_q[$];
  int   to_q[$];
  bit   in_frame = 1'b0;
  bit   tx_model_en = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Transmitter model: stop-bit level rises 4 cycles after launch and lasts 16 cycles
  initial forever begin
    @(negedge clk);
    if (tx_start && tx_model_en && !rst) begin
      repeat (4) @(negedge clk);
      tx_done = 1'b1;
      repeat (16) @(negedge clk);
      tx_done = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tx_start", 32'(tx_start), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("req_ack", 32'(req_ack), 32'(1) << e.id);
          check("grant_id", 32'(done_id), 32'(e.id));
          check("start_while_busy", 32'(in_frame), 32'd0);
          if (e.abort) to_q.push_back(e.id);
          else done_q.push_back(e.id);
        end
        in_frame = 1'b1;
      end else if (req_ack != '0) begin
        check("ack_without_start", 32'(req_ack), 32'd0);
      end
      if (done_pulse) begin
        if (done_q.size() == 0) check("unexpected_done_pulse", 32'(done_pulse), 32'd0);
        else check("done_id", 32'(done_id), 32'(done_q.pop_front()));
        in_frame = 1'b0;
      end
      if (timeout_err) begin
        if (to_q.size() == 0) check("unexpected_timeout_err", 32'(timeout_err), 32'd0);
        else check("timeout_id", 32'(done_id), 32'(to_q.pop_front()));
        in_frame = 1'b0;
      end
    end
  end

  task automatic set_byte(input int i, input logic [7:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic push_exp(input int id, input int data, input bit abort);
    exp_t e;
    e.id = id; e.data = data; e.abort = abort;
    exp_q.push_back(e);
  endtask

  // which: 0 tx_start, 1 done_pulse, 2 timeout_err, 3 tx_done
  task automatic wait_sig(input int which, input int budget, output int cycles);
    bit hit;
    hit = 1'b0;
    cycles = 0;
    while (!hit && cycles < budget) begin
      @(negedge clk);
      cycles++;
      case (which)
        0:       hit = tx_start;
        1:       hit = done_pulse;
        2:       hit = timeout_err;
        default: hit = tx_done;
      endcase
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL wait_event_%0d: no event within %0d cycles", which, budget);
    end
  endtask

  task automatic run_frame(input int lat, input bit drop, input bit clear_all);
    int c;
    wait_sig(0, 60, c);
    check("start_latency", 32'(c), 32'(lat));
    check("busy_at_start", 32'(busy), 32'd1);
    if (clear_all) req_valid = '0;
    else if (drop) req_valid = req_valid & ~req_ack;
    wait_sig(1, 60, c);
    check("done_latency", 32'(c), 32'd22);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); done_q.delete(); to_q.delete();
    in_frame = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_outputs", 32'({tx_start, req_ack, tx_data, done_pulse, done_id, timeout_err, busy}), 32'd0);

    // Single request from requester 2
    set_byte(2, 8'h5A);
    push_exp(2, 8'h5A, 1'b0);
    req_valid = 4'b0100;
    run_frame(2, 1'b1, 1'b0);

    // Pointer now 3: requests 3 and 0 -> 3 first, then 0 after wrap
    set_byte(3, 8'hC3);
    set_byte(0, 8'hA0);
    push_exp(3, 8'hC3, 1'b0);
    push_exp(0, 8'hA0, 1'b0);
    @(negedge clk);
    req_valid = 4'b1001;
    run_frame(2, 1'b1, 1'b0);
    run_frame(2, 1'b1, 1'b0);

    // Timeout: transmitter never answers
    tx_model_en = 1'b0;
    set_byte(0, 8'h77);
    push_exp(0, 8'h77, 1'b1);
    @(negedge clk);
    req_valid = 4'b0001;
    wait_sig(0, 20, c);
    check("to_start_latency", 32'(c), 32'd2);
    req_valid = req_valid & ~req_ack;
    wait_sig(2, 60, c);
    check("timeout_latency", 32'(c), 32'd32);
    check("busy_after_timeout", 32'(busy), 32'd0);
    check("no_done_on_timeout", 32'(done_pulse), 32'd0);
    repeat (5) @(negedge clk);
    tx_model_en = 1'b1;

    // Reset in WAIT_LO (pointer 1, request 2 granted)
    set_byte(2, 8'h3C);
    push_exp(2, 8'h3C, 1'b0);
    req_valid = 4'b0100;
    wait_sig(0, 20, c);
    check("rst_test_start_latency", 32'(c), 32'd2);
    req_valid = '0;
    wait_sig(3, 20, c);
    repeat (3) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    check("tx_data_before_reset", 32'(tx_data), 32'h3C);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs",
             32'({tx_start, req_ack, tx_data, done_pulse, done_id, timeout_err, busy}), 32'd0);
    done_q.delete();
    in_frame = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    set_byte(1, 8'h81);
    push_exp(1, 8'h81, 1'b0);
    req_valid = 4'b0010;
    run_frame(2, 1'b1, 1'b0);

    // All four continuously valid after reset: 0,1,2,3,0 back to back
    do_reset();
    set_byte(0, 8'h11); set_byte(1, 8'h22); set_byte(2, 8'h33); set_byte(3, 8'h44);
    push_exp(0, 8'h11, 1'b0); push_exp(1, 8'h22, 1'b0); push_exp(2, 8'h33, 1'b0);
    push_exp(3, 8'h44, 1'b0); push_exp(0, 8'h11, 1'b0);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) run_frame(2, 1'b0, i == 4);

    // Request withdrawn during START: latched byte still sent, only one ack
    set_byte(3, 8'hE7);
    push_exp(3, 8'hE7, 1'b0);
    @(negedge clk);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    check("start_not_in_start_cycle", 32'(tx_start), 32'd0);
    run_frame(1, 1'b0, 1'b0);
    repeat (30) @(negedge clk);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);
    check("to_q_empty", 32'(to_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
